// File: rtl/plab4_net_tp_domain_sched_pkg.sv
// Shared state encodings and helpers for the time-partitioned network scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package plab4_net_tp_domain_sched_pkg;

  // Width of the phase/state encoding seen by router control and trace logic.
  localparam int c_phase_nbits = 2;

  // Scheduler states; the encoding is exported verbatim on the phase output.
  typedef enum logic [c_phase_nbits-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_e;

  // Elaboration-time maximum, used to size the shared slot/guard counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/plab4_net_tp_slot_counter.sv
// Loadable saturating down-counter timing ACTIVE slots and GUARD intervals.
// Latency: load/decrement visible one cycle later; zero flag decoded from the register.
// Backpressure: none; decrement is ignored once the count reaches zero.
module plab4_net_tp_slot_counter #(
  parameter int p_width = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [p_width-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [p_width-1:0] count_q;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - p_width'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/plab4_net_tp_domain_sched.sv
// Round-robin security-domain scheduler with guard and drain phases between slots.
// Latency: state and all outputs are registered; en/net_idle act on the next edge.
// Backpressure: en=0 stops at the next guard boundary; net_idle=0 holds DRAIN indefinitely.
module plab4_net_tp_domain_sched
  import plab4_net_tp_domain_sched_pkg::*;
#(
  parameter int p_num_domains = 2,
  parameter int p_slot_cycles = 8,
  parameter int p_dead_cycles = 2,
  localparam int c_dom_nbits  = (p_num_domains > 2) ? $clog2(p_num_domains) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     net_idle,
  output logic [c_dom_nbits-1:0]   domain,
  output logic                     domain_val,
  output logic                     slot_start,
  output logic [c_phase_nbits-1:0] phase
);

  localparam int c_cnt_nbits = $clog2(max_int(p_slot_cycles, p_dead_cycles) + 1);

  localparam logic [c_cnt_nbits-1:0] c_slot_load = c_cnt_nbits'(p_slot_cycles - 1);
  localparam logic [c_cnt_nbits-1:0] c_dead_load = c_cnt_nbits'(p_dead_cycles - 1);
  localparam logic [c_dom_nbits-1:0] c_dom_last  = c_dom_nbits'(p_num_domains - 1);

  sched_state_e           state_q, state_d;
  logic [c_dom_nbits-1:0] domain_q, domain_d;
  logic                   domain_val_q;
  logic                   slot_start_q;

  logic                   cnt_load;
  logic [c_cnt_nbits-1:0] cnt_load_val;
  logic                   cnt_zero;

  // Next-state and next-domain selection; the domain only moves when a
  // guard/drain interval hands the network to the following slot.
  always_comb begin
    state_d  = state_q;
    domain_d = domain_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!en || cnt_zero) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (cnt_zero) begin
          if (net_idle) begin
            state_d  = en ? ST_ACTIVE : ST_IDLE;
            domain_d = (domain_q == c_dom_last) ? '0 : domain_q + c_dom_nbits'(1);
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (net_idle) begin
          state_d  = en ? ST_ACTIVE : ST_IDLE;
          domain_d = (domain_q == c_dom_last) ? '0 : domain_q + c_dom_nbits'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload the counter on every state change with the length of the new phase.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    if (state_d == ST_ACTIVE)     cnt_load_val = c_slot_load;
    else if (state_d == ST_GUARD) cnt_load_val = c_dead_load;
  end

  plab4_net_tp_slot_counter #(
    .p_width (c_cnt_nbits)
  ) u_slot_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (!cnt_load),
    .zero_o     (cnt_zero)
  );

  // FSM state plus registered outputs, so nothing is combinational on en/net_idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      domain_q     <= '0;
      domain_val_q <= 1'b0;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      domain_q     <= domain_d;
      domain_val_q <= (state_d == ST_ACTIVE);
      slot_start_q <= (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
    end
  end

  assign domain     = domain_q;
  assign domain_val = domain_val_q;
  assign slot_start = slot_start_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_plab4_net_tp_domain_sched.sv
// Directed bench: per-cycle input strings and hand-derived expected phase/domain/slot_start.
// Two instances: (2 domains, 4-cycle slot, 2-cycle guard) and (3 domains, 1, 1).
module tb_plab4_net_tp_domain_sched;

  logic       clk;
  logic       reset;
  logic       en;
  logic       net_idle;

  logic       domain_a;
  logic       domain_val_a;
  logic       slot_start_a;
  logic [1:0] phase_a;

  logic [1:0] domain_b;
  logic       domain_val_b;
  logic       slot_start_b;
  logic [1:0] phase_b;

  int n_checks = 0;
  int n_pass   = 0;

  plab4_net_tp_domain_sched #(
    .p_num_domains (2),
    .p_slot_cycles (4),
    .p_dead_cycles (2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .net_idle   (net_idle),
    .domain     (domain_a),
    .domain_val (domain_val_a),
    .slot_start (slot_start_a),
    .phase      (phase_a)
  );

  plab4_net_tp_domain_sched #(
    .p_num_domains (3),
    .p_slot_cycles (1),
    .p_dead_cycles (1)
  ) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .net_idle   (net_idle),
    .domain     (domain_b),
    .domain_val (domain_val_b),
    .slot_start (slot_start_b),
    .phase      (phase_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int digit(input string s, input int i);
    return int'(s[i]) - 48;
  endfunction

  // Cycle c starts 1 time unit after the c-th edge following reset release;
  // inputs from index c are applied then and outputs are checked against index c.
  task automatic run_scn(input string name, input int sel,
                         input string rst_s, input string en_s, input string idle_s,
                         input string ph_s, input string dom_s, input string ss_s);
    int n;
    int ph, dm, dv, ss;
    n = ph_s.len();
    reset = 1'b1; en = 1'b0; net_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      reset    = (digit(rst_s, c) != 0);
      en       = (digit(en_s, c) != 0);
      net_idle = (digit(idle_s, c) != 0);
      if (sel == 0) begin
        ph = int'(phase_a); dm = int'(domain_a); dv = int'(domain_val_a); ss = int'(slot_start_a);
      end else begin
        ph = int'(phase_b); dm = int'(domain_b); dv = int'(domain_val_b); ss = int'(slot_start_b);
      end
      check_eq($sformatf("%s c%0d phase", name, c), ph, digit(ph_s, c));
      check_eq($sformatf("%s c%0d domain", name, c), dm, digit(dom_s, c));
      check_eq($sformatf("%s c%0d domain_val", name, c), dv, (digit(ph_s, c) == 1) ? 1 : 0);
      check_eq($sformatf("%s c%0d slot_start", name, c), ss, digit(ss_s, c));
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; net_idle = 1'b1;
    // Reset must dominate en=1 from the first edges.
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset phase", int'(phase_a), 0);
    check_eq("reset domain", int'(domain_a), 0);
    check_eq("reset domain_val", int'(domain_val_a), 0);
    check_eq("reset slot_start", int'(slot_start_a), 0);
    check_eq("reset phase3", int'(phase_b), 0);
    check_eq("reset domain3", int'(domain_b), 0);

    // Full slots with a clean ring: ACTIVE 1-4, GUARD 5-6, domain wraps at 13.
    run_scn("basic", 0,
            "00000000000000",
            "11111111111111",
            "11111111111111",
            "01111221111221",
            "00000001111110",
            "01000001000001");

    // Busy ring at guard end: DRAIN 7-10, next slot at 11 for domain 1.
    run_scn("drain", 0,
            "000000000000",
            "111111111111",
            "111110000011",
            "011112233331",
            "000000000001",
            "010000000001");

    // en drops mid-slot: truncated slot, guard, IDLE pointing at domain 1.
    run_scn("stop", 0,
            "0000000000",
            "1100000011",
            "1111111111",
            "0112200001",
            "0000011111",
            "0100000001");

    // Reset mid-slot: immediate IDLE, no drain, then a fresh slot for domain 0.
    run_scn("rstmid", 0,
            "000100",
            "111111",
            "111111",
            "011101",
            "000000",
            "010001");

    // Three domains, one-cycle slot and guard: 0,1,2,0 every two cycles.
    run_scn("sweep", 1,
            "00000000",
            "11111111",
            "11111111",
            "01212121",
            "00011220",
            "01010101");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
